// File: rtl/i2s_rx_pkg.sv
// ============================================================================
// Module      : i2s_rx_pkg
// Description : Shared types and constants for the I2S receiver front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_rx_pkg;

    // Sample width shared with the downstream lowpass FIR datain port
    localparam int C_SAMPLE_W = 18;
    localparam int C_SLOT_MAX = 32;
    localparam int C_TIMEOUT  = 1024;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    // Bits needed to hold a counter that saturates at max_val
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ============================================================================
// Module      : i2s_sync_edge
// Description : Two-flop synchronisers for SCK/WS/SD plus SCK rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i2s_sck,
    input  logic i2s_ws,
    input  logic i2s_sd,
    output logic ws_s,
    output logic sd_s,
    output logic rise
);

    logic r_sck_m;
    logic r_sck_s;
    logic r_sck_d;
    logic r_ws_m;
    logic r_ws_s;
    logic r_sd_m;
    logic r_sd_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sck_m <= 1'b0;
            r_sck_s <= 1'b0;
            r_sck_d <= 1'b0;
            r_ws_m  <= 1'b0;
            r_ws_s  <= 1'b0;
            r_sd_m  <= 1'b0;
            r_sd_s  <= 1'b0;
        end else begin
            r_sck_m <= i2s_sck;
            r_sck_s <= r_sck_m;
            r_sck_d <= r_sck_s;
            r_ws_m  <= i2s_ws;
            r_ws_s  <= r_ws_m;
            r_sd_m  <= i2s_sd;
            r_sd_s  <= r_sd_m;
        end
    end

    assign ws_s = r_ws_s;
    assign sd_s = r_sd_s;
    assign rise = r_sck_s & ~r_sck_d;

endmodule

`default_nettype wire

// File: rtl/i2s_rx.sv
// ============================================================================
// Module      : i2s_rx
// Description : Oversampling I2S stereo receiver with frame hunt and SCK-loss timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W   = C_SAMPLE_W,
    parameter int SLOT_MAX = C_SLOT_MAX,
    parameter int TIMEOUT  = C_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    output logic [DATA_W-1:0] datal,
    output logic [DATA_W-1:0] datar,
    output logic              endata,
    output logic              lost_sync
);

    localparam int CNT_W = cnt_width(SLOT_MAX);
    localparam int TMO_W = $clog2(TIMEOUT);

    logic              w_ws_s;
    logic              w_sd_s;
    logic              w_rise;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_wsd;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_left_hold;
    logic [DATA_W-1:0] r_right_hold;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_pend;
    logic              w_bound;
    logic              w_tmo_fire;
    logic              w_latch_left;
    logic              w_emit;

    i2s_sync_edge u_sync (
        .clock   (clock),
        .reset   (reset),
        .i2s_sck (i2s_sck),
        .i2s_ws  (i2s_ws),
        .i2s_sd  (i2s_sd),
        .ws_s    (w_ws_s),
        .sd_s    (w_sd_s),
        .rise    (w_rise)
    );

    assign w_bound    = w_rise && (w_ws_s != r_wsd);
    // Fires on the step into TIMEOUT-1; the counter then parks there so it fires once
    assign w_tmo_fire = !w_rise && (r_tmo_cnt == TMO_W'(TIMEOUT - 2));

    // Current word with this rise's bit inserted; bits past DATA_W are dropped
    always_comb begin
        w_word = r_shreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(r_bit_cnt) == DATA_W - 1 - i) begin
                w_word[i] = w_sd_s;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch_left = 1'b0;
        w_emit       = 1'b0;
        if (w_tmo_fire) begin
            w_next_state = S_HUNT;
        end else if (w_bound) begin
            case (r_state)
                S_HUNT: begin
                    if (!w_ws_s) w_next_state = S_LEFT;
                end
                S_LEFT: begin
                    if (w_ws_s) begin
                        w_latch_left = 1'b1;
                        w_next_state = S_RIGHT;
                    end
                end
                S_RIGHT: begin
                    if (!w_ws_s) begin
                        w_emit       = 1'b1;
                        w_next_state = S_LEFT;
                    end
                end
                default: w_next_state = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wsd        <= 1'b0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_pend       <= 1'b0;
            datal        <= '0;
            datar        <= '0;
            endata       <= 1'b0;
            lost_sync    <= 1'b0;
        end else begin
            r_pend    <= 1'b0;
            endata    <= 1'b0;
            lost_sync <= w_tmo_fire;
            if (w_rise) begin
                r_tmo_cnt <= '0;
                r_wsd     <= w_ws_s;
                if (w_bound) begin
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_shreg <= w_word;
                    if (r_bit_cnt != CNT_W'(SLOT_MAX)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                if (w_latch_left) begin
                    r_left_hold <= w_word;
                end
                if (w_emit) begin
                    r_right_hold <= w_word;
                    r_pend       <= 1'b1;
                end
            end else if (w_tmo_fire) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                r_shreg   <= '0;
                r_bit_cnt <= '0;
            end else if (r_tmo_cnt != TMO_W'(TIMEOUT - 1)) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            // Completed pair leaves one register stage after the boundary rise
            if (r_pend) begin
                datal  <= r_left_hold;
                datar  <= r_right_hold;
                endata <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx.sv
// ============================================================================
// Module      : tb_i2s_rx
// Description : Self-checking bench for i2s_rx with a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_rx;

    localparam int HALF    = 4;
    localparam int TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i2s_sck = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_sd = 1'b0;
    logic [17:0] datal;
    logic [17:0] datar;
    logic        endata;
    logic        lost_sync;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_en     = 0;
    int          n_lost   = 0;
    int          n_push   = 0;
    int          cyc      = 0;
    int          rise_cyc = 0;
    logic        prev_en  = 1'b0;
    logic [17:0] exp_l[$];
    logic [17:0] exp_r[$];
    int          en_times[$];
    logic [17:0] last_l = '0;
    logic [17:0] last_r = '0;
    logic [17:0] m_l;
    logic [17:0] m_r;

    i2s_rx dut (
        .clock     (clock),
        .reset     (reset),
        .i2s_sck   (i2s_sck),
        .i2s_ws    (i2s_ws),
        .i2s_sd    (i2s_sd),
        .datal     (datal),
        .datar     (datar),
        .endata    (endata),
        .lost_sync (lost_sync)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: an N-bit MSB-first word seen through an 18-bit window
    function automatic logic [17:0] model(input logic [31:0] w, input int len);
        logic [63:0] v;
        v = 64'(w) & ((64'd1 << len) - 64'd1);
        if (len >= 18) v = v >> (len - 18);
        else           v = v << (18 - len);
        return v[17:0];
    endfunction

    always @(negedge clock) begin
        if (lost_sync) n_lost++;
        if (endata) begin
            n_en++;
            en_times.push_back(cyc);
            check("endata_one_cycle", 32'(prev_en), 0);
            check("endata_latency", cyc - rise_cyc, 4);
            check("endata_expected", 32'(exp_l.size() > 0), 1);
            if (exp_l.size() > 0) begin
                m_l = exp_l.pop_front();
                m_r = exp_r.pop_front();
                check("datal", 32'(datal), 32'(m_l));
                check("datar", 32'(datar), 32'(m_r));
            end
        end
        prev_en = endata;
    end

    task automatic send_bit(input logic ws, input logic sd);
        @(negedge clock);
        i2s_sck = 1'b0;
        i2s_ws  = ws;
        i2s_sd  = sd;
        repeat (HALF - 1) @(negedge clock);
        @(negedge clock);
        i2s_sck  = 1'b1;
        rise_cyc = cyc;
        repeat (HALF - 1) @(negedge clock);
    endtask

    // ws follows I2S: the word's last bit already carries the next channel's ws
    task automatic send_word(input logic ch, input logic nxt, input int len, input logic [31:0] w);
        for (int i = len - 1; i >= 0; i--) send_bit((i == 0) ? nxt : ch, w[i]);
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int len, input bit expect_out);
        if (expect_out) begin
            last_l = model(l, len);
            last_r = model(r, len);
            exp_l.push_back(last_l);
            exp_r.push_back(last_r);
            n_push++;
        end
        send_word(1'b0, 1'b1, len, l);
        send_word(1'b1, 1'b0, len, r);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && exp_l.size() != 0; i++) @(negedge clock);
        check(tag, exp_l.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lens[5];
        int len;
        int n_en0;
        int d;
        lens = '{16, 18, 20, 24, 32};

        // Reset held while SCK runs; join mid-left-word
        repeat (3) @(negedge clock);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        check("rst_datal", 32'(datal), 0);
        check("rst_datar", 32'(datar), 0);
        check("rst_endata", 32'(endata), 0);
        check("rst_lost", 32'(lost_sync), 0);
        reset = 1'b1;
        for (int i = 0; i < 13; i++) send_bit((i == 12) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        send_word(1'b1, 1'b0, 18, $urandom);
        check("hunt_no_endata", n_en, 0);
        frame(32'h2A5A5, 32'h15A5A, 18, 1'b1);
        drain("first_pair_drain");

        frame(32'h7FFFF000, 32'h80000FFF, 32, 1'b1);
        drain("long_slot_drain");
        frame(32'h8001, 32'h1234, 16, 1'b1);
        drain("short_slot_drain");

        // Continuous stream, 18-bit slots: 36 bits per frame
        en_times.delete();
        for (int k = 1; k <= 8; k++) frame(32'(k), 32'h3FFFF, 18, 1'b1);
        drain("stream_drain");
        check("stream_count", en_times.size(), 8);
        for (int k = 1; k < en_times.size(); k++) begin
            d = en_times[k] - en_times[k-1];
            check("stream_spacing", 32'(d >= 36 * 2 * HALF - 1 && d <= 36 * 2 * HALF + 1), 1);
        end

        for (int k = 0; k < 6; k++) begin
            len = lens[$urandom_range(0, 4)];
            frame($urandom, $urandom, len, 1'b1);
        end
        drain("random_drain");

        // SCK stall mid-right-word
        n_en0 = n_en;
        send_word(1'b0, 1'b1, 18, $urandom);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
        @(negedge clock);
        i2s_sck = 1'b0;
        repeat (TIMEOUT + 50) @(negedge clock);
        check("timeout_lost_once", n_lost, 1);
        check("timeout_no_endata", n_en, n_en0);
        check("timeout_hold_l", 32'(datal), 32'(last_l));
        check("timeout_hold_r", 32'(datar), 32'(last_r));
        send_word(1'b1, 1'b0, 18, $urandom);
        check("rehunt_no_endata", n_en, n_en0);
        frame($urandom, $urandom, 18, 1'b1);
        drain("rehunt_drain");

        // Asynchronous reset pulse inside the right word
        n_en0 = n_en;
        send_word(1'b0, 1'b1, 18, $urandom);
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("arst_datal", 32'(datal), 0);
        check("arst_datar", 32'(datar), 0);
        check("arst_endata", 32'(endata), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) send_bit((i == 8) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
        check("arst_no_partial", n_en, n_en0);
        frame($urandom, $urandom, 24, 1'b1);
        drain("arst_drain");

        repeat (20) @(negedge clock);
        check("total_endata", n_en, n_push);
        check("total_lost", n_lost, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Audio front-end receiver directly upstream of the lowpass FIR stage.
- Oversamples an external I2S link (SCK, WS, SD) in the system clock domain and deserialises stereo words.
- Presents 18-bit left/right samples with a one-cycle endata strobe per stereo frame, matching the filter's datain/endata input contract.
- Detects loss of link (SCK stall) and re-hunts frame alignment.

Parameters:
- DATA_W, 18, output sample width; equals the filter datain width.
- SLOT_MAX, 32, maximum SCK bits per channel slot; the bit counter saturates here.
- TIMEOUT, 1024, system clocks without an SCK rising edge before the link is declared lost.

Ports:
- clock  in  1  system clock; must be at least 4x SCK frequency.
- reset  in  1  asynchronous, active-low reset (reset==0 resets all state immediately).
- i2s_sck  in  1  I2S bit clock, asynchronous to clock.
- i2s_ws  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- i2s_sd  in  1  I2S serial data, asynchronous, MSB first.
- datal  out  DATA_W  last complete left sample, two's complement.
- datar  out  DATA_W  last complete right sample.
- endata  out  1  one-cycle pulse; datal/datar hold a new pair in the same cycle.
- lost_sync  out  1  one-cycle pulse when the timeout fires.

Behaviour:
- Reset values: datal=0, datar=0, endata=0, lost_sync=0, state=S_HUNT, shreg=0, bit_cnt=0, tmo_cnt=0.
- Synchronisers: two flops each on sck, ws and sd, plus one extra sck flop for edge detection.
- rise = sck_s & ~sck_d. All I2S processing happens only in cycles where rise=1.
- Per rise:
  - b = sd_s; wsd = ws_s captured at the previous rise.
  - If bit_cnt < DATA_W, write b into shreg[DATA_W-1-bit_cnt].
  - bit_cnt increments and saturates at SLOT_MAX. Bits beyond DATA_W are dropped, truncating long words.
  - Slots shorter than DATA_W leave the LSBs zero-padded.
- Word boundary:
  - Detected at a rise where ws_s != wsd.
  - The bit sampled at that rise belongs to the old word (standard I2S one-bit delay) and is written before the boundary is processed.
  - At the boundary: shreg and bit_cnt clear to 0 for the next word.
- FSM states: S_HUNT, S_LEFT, S_RIGHT.
  - S_HUNT: shreg contents are discarded. A boundary with ws_s=0 (right->left) goes to S_LEFT. Other boundaries are ignored.
  - S_LEFT: a boundary with ws_s=1 latches shreg into an internal left_hold and goes to S_RIGHT.
  - S_RIGHT: a boundary with ws_s=0 goes to S_LEFT and, registered on the next clock:
    - datal <= left_hold
    - datar <= shreg, including the bit from the boundary rise
    - endata <= 1 for exactly one cycle.
- Latency: endata rises 4 clocks after the SCK pin edge that completes the right word (2 sync + 1 edge + 1 output register).
- Timeout:
  - tmo_cnt clears on every rise and otherwise increments.
  - When it reaches TIMEOUT-1: state <= S_HUNT, shreg/bit_cnt clear, lost_sync pulses once, and tmo_cnt holds until the next rise.
  - datal/datar keep their last values.
- Simultaneous events: a rise in the same cycle as the timeout terminal count gives the rise priority; the timeout does not fire.
- First frame after reset or after lost sync: no endata until a full left word and a full right word have been received after the first right->left boundary.
- Asynchronous reset mid-word: all state clears and the receiver re-hunts; no partial sample is ever emitted.
- Only one endata is produced per stereo frame. endata never stays high two consecutive cycles.

Decomposition:
- Shared package:
  - state encoding S_HUNT/S_LEFT/S_RIGHT as 2-bit localparams
  - sample width constant shared with the lowpass stage (18)
  - bit-counter width derived from SLOT_MAX.
- One natural sub-module: i2s_sync_edge. It contains the 2-flop synchroniser for the three inputs plus the SCK rising-edge detector, and outputs ws_s, sd_s and rise.

Test Plan:
- Reset and hunt: reset=0 with SCK toggling, then released; start mid-left-word.
  - No endata is produced until a full L+R pair.
  - The first pair with L=18'h2A5A5, R=18'h15A5A (18-bit slots) gives datal=18'h2A5A5, datar=18'h15A5A and one endata pulse.
- Long slots: 32-bit slots carrying L=32'h7FFFF000, R=32'h80000FFF.
  - datal=18'h1FFFF, datar=18'h20000; low bits are dropped.
- Short slots: 16-bit slots carrying L=16'h8001.
  - datal=18'h20004 (LSBs zero-padded).
- Continuous stream: 8 consecutive frames with an incrementing left sample (1..8) and datar=-1 (18'h3FFFF).
  - Exactly 8 endata pulses, one per frame, with values in order.
  - endata spacing equals the frame period in clocks (+/-1).
- Timeout: SCK held low for TIMEOUT clocks mid-right-word.
  - lost_sync pulses once and no endata is produced.
  - The FSM re-hunts; the next full pair is output correctly.
- Async reset during the S_RIGHT word: reset pulsed low for 1 clock.
  - Outputs are immediately 0, with no endata for the interrupted frame.
  - The next complete frame is received correctly.
